// File: rtl/gps_emulator.sv
// Multi-satellite GPS L1 C/A baseband source: per-satellite carrier NCO, Gold-code
// generator and gain, plus LFSR noise, summed and quantised to 3-bit signed I/Q.
module gps_emulator #(
   parameter int          Nsat      = 4,
   parameter logic [31:0] CHIP_INC  = 32'd43937515,
   parameter int          OUT_SHIFT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [31:0]        freq       [Nsat],
   input  logic [15:0]        gain       [Nsat],
   input  logic [5:0]         ca_sel     [Nsat],
   input  logic [15:0]        noise_gain,
   output logic signed [2:0]  real_out,
   output logic signed [2:0]  imag_out
);

   localparam int          PW        = 26;
   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [31:0] SEED_I    = 32'hACE12468;
   localparam logic [31:0] SEED_Q    = 32'h13579BDF;

   function automatic logic signed [7:0] cos_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    cos_lut =  8'sd125;
         4'd1:    cos_lut =  8'sd106;
         4'd2:    cos_lut =  8'sd71;
         4'd3:    cos_lut =  8'sd25;
         4'd4:    cos_lut = -8'sd25;
         4'd5:    cos_lut = -8'sd71;
         4'd6:    cos_lut = -8'sd106;
         4'd7:    cos_lut = -8'sd125;
         4'd8:    cos_lut = -8'sd125;
         4'd9:    cos_lut = -8'sd106;
         4'd10:   cos_lut = -8'sd71;
         4'd11:   cos_lut = -8'sd25;
         4'd12:   cos_lut =  8'sd25;
         4'd13:   cos_lut =  8'sd71;
         4'd14:   cos_lut =  8'sd106;
         4'd15:   cos_lut =  8'sd125;
         default: cos_lut =  8'sd0;
      endcase
   endfunction

   // sin at bin i equals cos a quarter turn (4 bins) earlier
   function automatic logic signed [7:0] sin_lut(input logic [3:0] idx);
      sin_lut = cos_lut(idx - 4'd4);
   endfunction

   // Zero-based G2 stage pair {a,b} for each code select; 36..63 reuse SV36
   function automatic logic [7:0] g2_taps(input logic [5:0] sel);
      case (sel)
         6'd0:  g2_taps = 8'h15;
         6'd1:  g2_taps = 8'h26;
         6'd2:  g2_taps = 8'h37;
         6'd3:  g2_taps = 8'h48;
         6'd4:  g2_taps = 8'h08;
         6'd5:  g2_taps = 8'h19;
         6'd6:  g2_taps = 8'h07;
         6'd7:  g2_taps = 8'h18;
         6'd8:  g2_taps = 8'h29;
         6'd9:  g2_taps = 8'h12;
         6'd10: g2_taps = 8'h23;
         6'd11: g2_taps = 8'h45;
         6'd12: g2_taps = 8'h56;
         6'd13: g2_taps = 8'h67;
         6'd14: g2_taps = 8'h78;
         6'd15: g2_taps = 8'h89;
         6'd16: g2_taps = 8'h03;
         6'd17: g2_taps = 8'h14;
         6'd18: g2_taps = 8'h25;
         6'd19: g2_taps = 8'h36;
         6'd20: g2_taps = 8'h47;
         6'd21: g2_taps = 8'h58;
         6'd22: g2_taps = 8'h02;
         6'd23: g2_taps = 8'h35;
         6'd24: g2_taps = 8'h46;
         6'd25: g2_taps = 8'h57;
         6'd26: g2_taps = 8'h68;
         6'd27: g2_taps = 8'h79;
         6'd28: g2_taps = 8'h05;
         6'd29: g2_taps = 8'h16;
         6'd30: g2_taps = 8'h27;
         6'd31: g2_taps = 8'h38;
         6'd32: g2_taps = 8'h49;
         6'd33: g2_taps = 8'h39;
         6'd34: g2_taps = 8'h06;
         default: g2_taps = 8'h17;
      endcase
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      lfsr_step = (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
   endfunction

   function automatic logic signed [2:0] saturate(input logic signed [PW-1:0] v);
      if (v > 26'sd3)
         saturate = 3'sd3;
      else if (v < -26'sd4)
         saturate = -3'sd4;
      else
         saturate = v[2:0];
   endfunction

   logic [31:0]              phase    [Nsat];
   logic [31:0]              chip_acc [Nsat];
   logic [9:0]               g1       [Nsat];
   logic [9:0]               g2       [Nsat];
   logic [31:0]              lfsr_i;
   logic [31:0]              lfsr_q;

   logic [32:0]              chip_sum [Nsat];
   logic [9:0]               g1_next  [Nsat];
   logic [9:0]               g2_next  [Nsat];
   logic                     code_bit [Nsat];
   logic [7:0]               taps     [Nsat];

   logic signed [8:0]        s1_i     [Nsat];
   logic signed [8:0]        s1_q     [Nsat];
   logic signed [7:0]        s1_ni;
   logic signed [7:0]        s1_nq;

   logic signed [PW-1:0]     s2_i     [Nsat];
   logic signed [PW-1:0]     s2_q     [Nsat];
   logic signed [PW-1:0]     s2_ni;
   logic signed [PW-1:0]     s2_nq;

   logic signed [PW-1:0]     sum_i;
   logic signed [PW-1:0]     sum_q;

   // Chip-NCO carry, next Gold-register states and the current code bit per satellite
   always_comb begin
      for (int k = 0; k < Nsat; k++) begin
         chip_sum[k] = {1'b0, chip_acc[k]} + {1'b0, CHIP_INC};
         g1_next[k]  = {g1[k][8:0], g1[k][2] ^ g1[k][9]};
         g2_next[k]  = {g2[k][8:0], g2[k][1] ^ g2[k][2] ^ g2[k][5] ^
                                    g2[k][7] ^ g2[k][8] ^ g2[k][9]};
         taps[k]     = g2_taps(ca_sel[k]);
         code_bit[k] = g1[k][9] ^ g2[k][taps[k][7:4]] ^ g2[k][taps[k][3:0]];
      end
   end

   // S0: generator state, advancing only while enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < Nsat; k++) begin
            phase[k]    <= 32'h0;
            chip_acc[k] <= 32'h0;
            g1[k]       <= 10'h3FF;
            g2[k]       <= 10'h3FF;
         end
         lfsr_i <= SEED_I;
         lfsr_q <= SEED_Q;
      end else if (enable) begin
         for (int k = 0; k < Nsat; k++) begin
            phase[k]    <= phase[k] + freq[k];
            chip_acc[k] <= chip_sum[k][31:0];
            if (chip_sum[k][32]) begin
               g1[k] <= g1_next[k];
               g2[k] <= g2_next[k];
            end
         end
         lfsr_i <= lfsr_step(lfsr_i);
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   // S1: carrier sample with the chip sign applied, plus raw noise samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < Nsat; k++) begin
            s1_i[k] <= 9'sd0;
            s1_q[k] <= 9'sd0;
         end
         s1_ni <= 8'sd0;
         s1_nq <= 8'sd0;
      end else begin
         for (int k = 0; k < Nsat; k++) begin
            if (code_bit[k]) begin
               s1_i[k] <= -9'(cos_lut(phase[k][31:28]));
               s1_q[k] <= -9'(sin_lut(phase[k][31:28]));
            end else begin
               s1_i[k] <= 9'(cos_lut(phase[k][31:28]));
               s1_q[k] <= 9'(sin_lut(phase[k][31:28]));
            end
         end
         s1_ni <= lfsr_i[7:0];
         s1_nq <= lfsr_q[7:0];
      end
   end

   // S2: gain and noise-gain products, floor-shifted back to sample scale
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < Nsat; k++) begin
            s2_i[k] <= 26'sd0;
            s2_q[k] <= 26'sd0;
         end
         s2_ni <= 26'sd0;
         s2_nq <= 26'sd0;
      end else begin
         for (int k = 0; k < Nsat; k++) begin
            s2_i[k] <= (PW'(s1_i[k]) * PW'($signed({1'b0, gain[k]}))) >>> 16;
            s2_q[k] <= (PW'(s1_q[k]) * PW'($signed({1'b0, gain[k]}))) >>> 16;
         end
         s2_ni <= (PW'(s1_ni) * PW'($signed({1'b0, noise_gain}))) >>> 16;
         s2_nq <= (PW'(s1_nq) * PW'($signed({1'b0, noise_gain}))) >>> 16;
      end
   end

   // Wide accumulation of all satellite terms and noise
   always_comb begin
      sum_i = s2_ni;
      sum_q = s2_nq;
      for (int k = 0; k < Nsat; k++) begin
         sum_i = sum_i + s2_i[k];
         sum_q = sum_q + s2_q[k];
      end
   end

   // S3: scale and saturate into the 3-bit outputs; forced to zero when disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         real_out <= 3'sd0;
         imag_out <= 3'sd0;
      end else if (enable) begin
         real_out <= saturate(sum_i >>> OUT_SHIFT);
         imag_out <= saturate(sum_q >>> OUT_SHIFT);
      end else begin
         real_out <= 3'sd0;
         imag_out <= 3'sd0;
      end
   end

endmodule

// File: tb/tb_gps_emulator.sv
// Directed self-checking bench for gps_emulator: reset, zero gain, SV1/SV2 code
// chips, carrier rotation and LFSR noise with an enable pause.
module tb_gps_emulator;

   localparam int NS = 4;
   localparam longint CHIP = 43937515;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic [31:0]        freq   [NS];
   logic [15:0]        gain   [NS];
   logic [5:0]         ca_sel [NS];
   logic [15:0]        noise_gain;
   logic signed [2:0]  real_out;
   logic signed [2:0]  imag_out;

   int n_assert = 0;
   int n_fail   = 0;

   int cos_t [16] = '{125, 106, 71, 25, -25, -71, -106, -125,
                      -125, -106, -71, -25, 25, 71, 106, 125};
   int sin_t [16] = '{25, 71, 106, 125, 125, 106, 71, 25,
                      -25, -71, -106, -125, -125, -106, -71, -25};

   logic [31:0] li [100];
   logic [31:0] lq [100];

   gps_emulator dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .freq       (freq),
      .gain       (gain),
      .ca_sel     (ca_sel),
      .noise_gain (noise_gain),
      .real_out   (real_out),
      .imag_out   (imag_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      reset  = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
      tick();
   endtask

   function automatic int sat3(input int s);
      int v;
      v = s >>> 4;
      if (v > 3) return 3;
      else if (v < -4) return -4;
      else return v;
   endfunction

   function automatic int scale(input int v, input int g);
      return (v * g) >>> 16;
   endfunction

   function automatic int chip_of(input int n);
      longint p;
      p = longint'(n) * CHIP;
      return int'(p >>> 32);
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
   endfunction

   // First ten chips of a code from reset, sat0 alone at zero Doppler
   task automatic run_code(input string tag, input logic [5:0] sel, input logic [9:0] pat);
      int n;
      int c;
      do_reset();
      freq[0]   = 32'h0;
      gain[0]   = 16'hFFFF;
      ca_sel[0] = sel;
      enable    = 1'b1;
      for (int m = 1; m <= 985; m++) begin
         tick();
         if (m >= 3) begin
            n = m - 3;
            c = chip_of(n);
            if (c < 10) begin
               check({tag, "_i"}, real_out, pat[9-c] ? -4 : 3);
               check({tag, "_q"}, imag_out, pat[9-c] ? -2 : 1);
            end
         end
      end
   endtask

   initial begin
      int n;
      int idx;
      int any_nz;
      longint p;

      li[0] = 32'hACE12468;
      lq[0] = 32'h13579BDF;
      for (int i = 1; i < 100; i++) begin
         li[i] = lfsr_next(li[i-1]);
         lq[i] = lfsr_next(lq[i-1]);
      end

      // Outputs held at zero while reset is high, even with everything active
      reset  = 1'b1;
      enable = 1'b1;
      for (int k = 0; k < NS; k++) begin
         freq[k]   = 32'h01000000 * (k + 1);
         gain[k]   = 16'h1000;
         ca_sel[k] = 6'(k);
      end
      noise_gain = 16'h1000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_real", real_out, 0);
         check("rst_imag", imag_out, 0);
      end

      // All gains zero: silent output
      for (int k = 0; k < NS; k++) gain[k] = 16'h0;
      noise_gain = 16'h0;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("zero_real", real_out, 0);
         check("zero_imag", imag_out, 0);
      end

      run_code("sv1", 6'd0, 10'b1100100000);
      gain[0] = 16'h0;
      run_code("sv2", 6'd1, 10'b1110010000);

      // Carrier rotation during chip 0 (SV1 chip 0 is a 1, i.e. -1)
      do_reset();
      freq[0]   = 32'h028F5C29;
      gain[0]   = 16'hFFFF;
      ca_sel[0] = 6'd0;
      enable    = 1'b1;
      for (int m = 1; m <= 100; m++) begin
         tick();
         if (m >= 3) begin
            n   = m - 3;
            p   = longint'(n) * longint'(32'h028F5C29);
            idx = int'((p >>> 28) & 64'hF);
            check("carrier_i", real_out, sat3(scale(-cos_t[idx], 65535)));
            check("carrier_q", imag_out, sat3(scale(-sin_t[idx], 65535)));
         end
      end

      // Noise only: exact LFSR sequence, then pause and resume
      do_reset();
      gain[0]    = 16'h0;
      freq[0]    = 32'h0;
      noise_gain = 16'hFFFF;
      enable     = 1'b1;
      any_nz     = 0;
      for (int m = 1; m <= 40; m++) begin
         tick();
         if (m >= 3) begin
            n = m - 3;
            check("noise_i", real_out, sat3(scale(int'($signed(li[n][7:0])), 65535)));
            check("noise_q", imag_out, sat3(scale(int'($signed(lq[n][7:0])), 65535)));
            if (n < 16 && (real_out != 3'sd0 || imag_out != 3'sd0)) any_nz = 1;
         end
      end
      check("noise_nonzero", any_nz, 1);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pause_i", real_out, 0);
         check("pause_q", imag_out, 0);
      end
      enable = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         tick();
         if (j >= 3) begin
            n = 40 + j - 3;
            check("resume_i", real_out, sat3(scale(int'($signed(li[n][7:0])), 65535)));
            check("resume_q", imag_out, sat3(scale(int'($signed(lq[n][7:0])), 65535)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
